// File: rtl/rr_lock_arbiter_if.sv
// -----------------------------------------------------------------------------
// rr_lock_arbiter_if
//   Request/grant bundle between the per-app requesters and the round-robin
//   lock arbiter.
//
//   req          requester -> arbiter  one level-sensitive request per app
//   beat_fire    downstream -> arbiter downstream accepted a beat (valid&ready)
//   beat_last    downstream -> arbiter accepted beat is the transfer's last
//   grant        arbiter -> encoder    registered one-hot grant, zero when idle
//   grant_valid  arbiter -> encoder    registered, equals |grant
//
//   master : requester/downstream side (drives req and beat qualifiers)
//   slave  : arbiter side (drives grant and grant_valid)
// -----------------------------------------------------------------------------
interface rr_lock_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0] req;
  logic               beat_fire;
  logic               beat_last;
  logic [NUM_REQ-1:0] grant;
  logic               grant_valid;

  modport master (
    output req, beat_fire, beat_last,
    input  grant, grant_valid
  );

  modport slave (
    input  req, beat_fire, beat_last,
    output grant, grant_valid
  );
endinterface

// File: rtl/rr_lock_arbiter.sv
// -----------------------------------------------------------------------------
// rr_lock_arbiter
//   Round-robin arbiter whose registered one-hot grant feeds the
//   one-hot-to-select encoder of the shared-channel data mux. A grant is locked
//   for the whole transfer and released only when the last beat is accepted
//   downstream (beat_fire && beat_last). After release the priority pointer
//   moves one past the winner, so the winner has lowest priority next time.
//   One idle cycle separates consecutive transfers; arbitration happens there.
//
//   Parameters
//     NUM_REQ    number of requesters (1, 2, 4 or 8)
//     PTR_WIDTH  priority pointer width, max(1, log2(NUM_REQ))
//
//   Ports
//     clk   system clock, rising edge
//     rst   asynchronous, active-high reset
//     bus   rr_lock_arbiter_if.slave: req, beat_fire, beat_last in;
//           grant, grant_valid out
// -----------------------------------------------------------------------------
module rr_lock_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int PTR_WIDTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  rr_lock_arbiter_if.slave   bus
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic                 grant_valid_q;
  logic [PTR_WIDTH-1:0] ptr_q, ptr_d;
  logic [PTR_WIDTH-1:0] win_q, win_d;
  int                   pick;

  // Returns the index of the first set request found scanning ptr, ptr+1, ...
  // modulo NUM_REQ, or -1 when nothing is requesting. Scanning offsets from
  // the far end back toward ptr lets the nearest candidate overwrite the rest.
  function automatic int rr_pick(input logic [NUM_REQ-1:0]   r,
                                 input logic [PTR_WIDTH-1:0] p);
    int w;
    int cand;
    w = -1;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = (int'(p) + k) % NUM_REQ;
      if ((r & (NUM_REQ'(1) << cand)) != '0) begin
        w = cand;
      end
    end
    return w;
  endfunction

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    pick    = rr_pick(bus.req, ptr_q);

    case (state_q)
      IDLE: begin
        // beat_fire/beat_last carry no meaning without an owner.
        if (pick >= 0) begin
          grant_d = NUM_REQ'(1) << pick;
          win_d   = PTR_WIDTH'(pick);
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        // Grant is frozen regardless of req; only the accepted last beat
        // ends the transfer.
        if (bus.beat_fire && bus.beat_last) begin
          grant_d = '0;
          ptr_d   = PTR_WIDTH'((int'(win_q) + 1) % NUM_REQ);
          state_d = IDLE;
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: only control/pointer flops live here (no storage arrays), so all of
  // them are cleared by reset to give a known IDLE state with ptr at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      ptr_q         <= '0;
      win_q         <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_valid_q <= |grant_d;
      ptr_q         <= ptr_d;
      win_q         <= win_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_valid = grant_valid_q;

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_lock_arbiter
//   Three arbiter builds (NUM_REQ = 4, 1, 8) share one clock and reset.
//   A vector table drives the 4-requester build through rotation, multi-beat
//   lock and ignored-qualifier cases; hand sequences cover reset mid-transfer
//   and the 1/8-requester builds; a random phase compares all builds against
//   an index-based reference model.
// -----------------------------------------------------------------------------
module tb_rr_lock_arbiter;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  rr_lock_arbiter_if #(.NUM_REQ(4)) bus4 ();
  rr_lock_arbiter_if #(.NUM_REQ(1)) bus1 ();
  rr_lock_arbiter_if #(.NUM_REQ(8)) bus8 ();

  rr_lock_arbiter #(.NUM_REQ(4), .PTR_WIDTH(2)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  rr_lock_arbiter #(.NUM_REQ(1), .PTR_WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  rr_lock_arbiter #(.NUM_REQ(8), .PTR_WIDTH(3)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Grant must be one-hot or zero and grant_valid must track it, every cycle.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      check("onehot4", 8'($onehot0(bus4.grant)), 8'd1);
      check("onehot1", 8'($onehot0(bus1.grant)), 8'd1);
      check("onehot8", 8'($onehot0(bus8.grant)), 8'd1);
      check("gv4", 8'(bus4.grant_valid), 8'(|bus4.grant));
      check("gv8", 8'(bus8.grant_valid), 8'(|bus8.grant));
    end
  end

  typedef struct {
    logic [3:0] req;
    logic       fire;
    logic       last;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [3:0] r, input logic f, input logic l,
                              input logic [3:0] e);
    vec_t v;
    v.req = r; v.fire = f; v.last = l; v.exp = e;
    vecs.push_back(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: owner index (-1 = nobody) and a priority pointer.
  task automatic model_step(input int n, input logic [7:0] r, input logic f,
                            input logic l, inout int owner, inout int ptr);
    int j;
    if (owner < 0) begin
      for (int k = 0; k < n; k++) begin
        j = (ptr + k) % n;
        if (r[j[2:0]]) begin
          owner = j;
          break;
        end
      end
    end else if (f && l) begin
      ptr   = (owner + 1) % n;
      owner = -1;
    end
  endtask

  function automatic logic [7:0] owner_grant(input int owner);
    return (owner < 0) ? 8'h00 : (8'h01 << owner);
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int o4, p4, o1, p1, o8, p8;
    logic [7:0] r;

    // ---------------- reset with all requesting ----------------
    rst = 1'b1;
    bus4.req = 4'hF; bus4.beat_fire = 1'b0; bus4.beat_last = 1'b0;
    bus1.req = 1'b0; bus1.beat_fire = 1'b0; bus1.beat_last = 1'b0;
    bus8.req = 8'h0; bus8.beat_fire = 1'b0; bus8.beat_last = 1'b0;
    #12;
    check("rst_grant", 8'(bus4.grant), 8'h00);
    check("rst_gv", 8'(bus4.grant_valid), 8'h00);
    tick();
    rst = 1'b0;

    // ---------------- vector table (NUM_REQ=4) ----------------
    // rotation with 1-beat transfers, including pointer wrap 3 -> 0
    add(4'hF, 0, 0, 4'b0001); add(4'hF, 1, 1, 4'b0000);
    add(4'hF, 0, 0, 4'b0010); add(4'hF, 1, 1, 4'b0000);
    add(4'hF, 0, 0, 4'b0100); add(4'hF, 1, 1, 4'b0000);
    add(4'hF, 0, 0, 4'b1000); add(4'hF, 1, 1, 4'b0000);
    add(4'hF, 0, 0, 4'b0001); add(4'hF, 1, 1, 4'b0000);   // ptr -> 1
    // 3-beat transfer on 0100 with everybody requesting
    add(4'b0100, 0, 0, 4'b0100);
    add(4'hF, 1, 0, 4'b0100); add(4'hF, 1, 0, 4'b0100);
    add(4'hF, 1, 1, 4'b0000);                               // ptr -> 3
    add(4'hF, 0, 0, 4'b1000); add(4'hF, 1, 1, 4'b0000);   // ptr -> 0
    // last without fire is ignored; winner dropping req keeps the lock
    add(4'b0010, 0, 0, 4'b0010);
    for (int i = 0; i < 5; i++) add(4'hF, 0, 1, 4'b0010);
    add(4'h0, 0, 0, 4'b0010); add(4'h0, 1, 0, 4'b0010);
    add(4'h0, 1, 1, 4'b0000);                               // ptr -> 2
    // qualifiers while idle do nothing
    add(4'h0, 1, 1, 4'b0000); add(4'h0, 0, 0, 4'b0000);
    // scan from ptr=2 wraps to requester 0
    add(4'b0001, 0, 0, 4'b0001); add(4'hF, 1, 1, 4'b0000); // ptr -> 1

    foreach (vecs[i]) begin
      bus4.req       = vecs[i].req;
      bus4.beat_fire = vecs[i].fire;
      bus4.beat_last = vecs[i].last;
      tick();
      check($sformatf("tbl%0d_grant", i), 8'(bus4.grant), 8'(vecs[i].exp));
      check($sformatf("tbl%0d_gv", i), 8'(bus4.grant_valid), 8'(|vecs[i].exp));
    end

    // ---------------- reset mid-transfer ----------------
    bus4.req = 4'b1000; bus4.beat_fire = 1'b0; bus4.beat_last = 1'b0;
    tick();
    check("mid_lock", 8'(bus4.grant), 8'b1000);
    bus4.req = 4'hF; bus4.beat_fire = 1'b1; bus4.beat_last = 1'b0;
    tick();
    check("mid_beat", 8'(bus4.grant), 8'b1000);
    #2 rst = 1'b1;
    #1;
    check("async_rst_grant", 8'(bus4.grant), 8'h00);
    check("async_rst_gv", 8'(bus4.grant_valid), 8'h00);
    #3;
    rst = 1'b0;
    bus4.req = 4'b1010; bus4.beat_fire = 1'b0; bus4.beat_last = 1'b0;
    tick();
    check("post_rst_grant", 8'(bus4.grant), 8'b0010);
    bus4.beat_fire = 1'b1; bus4.beat_last = 1'b1;
    tick();
    check("post_rst_release", 8'(bus4.grant), 8'h00);

    // ---------------- NUM_REQ=1 and NUM_REQ=8 rotation ----------------
    bus4.req = 4'h0; bus4.beat_fire = 1'b0; bus4.beat_last = 1'b0;
    for (int k = 0; k < 9; k++) begin
      bus8.req = 8'hFF; bus8.beat_fire = 1'b0; bus8.beat_last = 1'b0;
      bus1.req = 1'b1;  bus1.beat_fire = 1'b0; bus1.beat_last = 1'b0;
      tick();
      check($sformatf("rot8_%0d", k), bus8.grant, 8'h01 << (k % 8));
      check($sformatf("one1_%0d", k), 8'(bus1.grant), 8'h01);
      bus8.beat_fire = 1'b1; bus8.beat_last = 1'b1;
      bus1.beat_fire = 1'b1; bus1.beat_last = 1'b1;
      tick();
      check($sformatf("rel8_%0d", k), bus8.grant, 8'h00);
      check($sformatf("rel1_%0d", k), 8'(bus1.grant), 8'h00);
    end

    // ---------------- random vs reference model ----------------
    bus1.beat_fire = 1'b0; bus1.beat_last = 1'b0; bus1.req = 1'b0;
    bus8.beat_fire = 1'b0; bus8.beat_last = 1'b0; bus8.req = 8'h0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    o4 = -1; p4 = 0; o1 = -1; p1 = 0; o8 = -1; p8 = 0;

    for (int c = 0; c < 400; c++) begin
      r = 8'($urandom);
      bus4.req = r[3:0];
      bus4.beat_fire = 1'($urandom_range(0, 1));
      bus4.beat_last = 1'($urandom_range(0, 1));
      r = 8'($urandom);
      bus1.req = r[0];
      bus1.beat_fire = 1'($urandom_range(0, 1));
      bus1.beat_last = 1'($urandom_range(0, 1));
      r = 8'($urandom);
      bus8.req = r;
      bus8.beat_fire = 1'($urandom_range(0, 1));
      bus8.beat_last = 1'($urandom_range(0, 1));

      model_step(4, 8'(bus4.req), bus4.beat_fire, bus4.beat_last, o4, p4);
      model_step(1, 8'(bus1.req), bus1.beat_fire, bus1.beat_last, o1, p1);
      model_step(8, bus8.req,     bus8.beat_fire, bus8.beat_last, o8, p8);
      tick();
      check($sformatf("rnd4_%0d", c), 8'(bus4.grant), owner_grant(o4));
      check($sformatf("rnd1_%0d", c), 8'(bus1.grant), owner_grant(o1));
      check($sformatf("rnd8_%0d", c), bus8.grant, owner_grant(o8));
      check($sformatf("rnd1gv_%0d", c), 8'(bus1.grant_valid), 8'(o1 >= 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
